// File: rtl/i2c_9555_master_if.sv
// Host handshake plus open-drain pad signals of the expander register-access master.
// The master modport is the initiator's view; the slave modport is the host/pad side.
interface i2c_9555_master_if;
   logic       start;
   logic       rw;
   logic [7:0] cmd_addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [7:0] rdata;
   logic       scl_oe;
   logic       sda_oe;
   logic       scl_in;
   logic       sda_in;

   modport master (
      input  start, rw, cmd_addr, wdata, scl_in, sda_in,
      output busy, done, ack_err, rdata, scl_oe, sda_oe
   );

   modport slave (
      output start, rw, cmd_addr, wdata, scl_in, sda_in,
      input  busy, done, ack_err, rdata, scl_oe, sda_oe
   );
endinterface

// File: rtl/i2c_9555_master.sv
// I2C single-master initiator: one register write or read on a PCA9555-style expander.
// Each bit is four quarters of QTR clocks; SCL stretching freezes the quarter counter.
module i2c_9555_master #(
   parameter int         CLK_HZ   = 50_000_000,
   parameter int         SCL_HZ   = 100_000,
   parameter logic [6:0] DEV_ADDR = 7'h20
) (
   input logic               clk,
   input logic               rst_l,
   i2c_9555_master_if.master bus
);
   localparam int            QTR   = CLK_HZ / (4 * SCL_HZ);
   localparam int            QW    = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

   typedef enum logic [3:0] {
      IDLE, BUSWAIT, START, TXBIT, ACK, RSTART, RXBIT, MNACK, STOP
   } state_t;

   state_t        state, state_nxt;
   logic [QW-1:0] qcnt;
   logic [1:0]    q;
   logic [2:0]    bcnt;
   logic [1:0]    byte_idx;
   logic          rw_r, ack_bit;
   logic          busy, done, ack_err, scl_oe, sda_oe;
   logic [7:0]    rdata, shreg, cmd_r, wdata_r;
   logic          scl_nxt, sda_nxt, accept, bit_state, timed, stretch, tick, q_end;
   logic          bus_idle, scl_pat;

   assign accept    = bus.start && !busy;
   assign bit_state = state inside {TXBIT, ACK, RSTART, RXBIT, MNACK, STOP};
   assign timed     = bit_state || (state == START);
   // A slave holding SCL low while we have released it freezes the bit timing.
   assign stretch   = bit_state && (q == 2'd1 || q == 2'd2) && !scl_oe && !bus.scl_in;
   assign tick      = (qcnt == QLAST) && !stretch;
   assign q_end     = tick && (q == 2'd3);
   assign bus_idle  = bus.scl_in && bus.sda_in;
   assign scl_pat   = (q == 2'd0) || (q == 2'd3);

   always_comb begin
      state_nxt = state;
      scl_nxt   = 1'b0;
      sda_nxt   = 1'b0;
      case (state)
         IDLE:    if (accept) state_nxt = BUSWAIT;
         BUSWAIT: if (bus_idle && qcnt == QLAST) state_nxt = START;
         START: begin
            sda_nxt = 1'b1;
            scl_nxt = (q == 2'd1);
            if (tick && q == 2'd1) state_nxt = TXBIT;
         end
         TXBIT: begin
            scl_nxt = scl_pat;
            sda_nxt = !shreg[7];
            if (q_end && bcnt == 3'd7) state_nxt = ACK;
         end
         ACK: begin
            scl_nxt = scl_pat;
            if (q_end) begin
               if (ack_bit) state_nxt = STOP;
               else begin
                  case (byte_idx)
                     2'd0:    state_nxt = TXBIT;
                     2'd1:    state_nxt = rw_r ? RSTART : TXBIT;
                     2'd2:    state_nxt = STOP;
                     default: state_nxt = RXBIT;
                  endcase
               end
            end
         end
         RSTART: begin
            scl_nxt = scl_pat;
            sda_nxt = q[1];
            if (q_end) state_nxt = TXBIT;
         end
         RXBIT: begin
            scl_nxt = scl_pat;
            if (q_end && bcnt == 3'd7) state_nxt = MNACK;
         end
         MNACK: begin
            scl_nxt = scl_pat;
            if (q_end) state_nxt = STOP;
         end
         STOP: begin
            scl_nxt = (q == 2'd0);
            sda_nxt = !q[1];
            if (q_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state    <= IDLE;
         qcnt     <= '0;
         q        <= 2'd0;
         bcnt     <= 3'd0;
         byte_idx <= 2'd0;
         rw_r     <= 1'b0;
         ack_bit  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
         rdata    <= 8'h00;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
      end else begin
         state  <= state_nxt;
         scl_oe <= scl_nxt;
         sda_oe <= sda_nxt;
         done   <= 1'b0;
         if (done) busy <= 1'b0;
         if (accept) begin
            busy    <= 1'b1;
            ack_err <= 1'b0;
            rw_r    <= bus.rw;
         end
         // BUSWAIT reuses the quarter counter to time a full idle quarter.
         if (state == BUSWAIT) qcnt <= (bus_idle && qcnt != QLAST) ? qcnt + 1'b1 : '0;
         else if (timed) begin
            if (!stretch) qcnt <= (qcnt == QLAST) ? '0 : qcnt + 1'b1;
         end else qcnt <= '0;
         if (timed && tick) q <= (state_nxt != state) ? 2'd0 : q + 2'd1;
         if (q_end && (state == TXBIT || state == RXBIT)) bcnt <= bcnt + 3'd1;
         if (state == START && tick && q == 2'd1) byte_idx <= 2'd0;
         if (state == ACK && tick && q == 2'd2) begin
            ack_bit <= bus.sda_in;
            if (bus.sda_in) ack_err <= 1'b1;
         end
         if (state == ACK && q_end && !ack_bit)
            byte_idx <= (byte_idx == 2'd1 && rw_r) ? 2'd3 : byte_idx + 2'd1;
         if (state == STOP && q_end) begin
            done <= 1'b1;
            if (rw_r && !ack_err) rdata <= shreg;
         end
      end
   end

   // Shared shift register: transmit bytes go out MSB first, the read byte shifts in.
   always_ff @(posedge clk) begin
      if (accept) begin
         cmd_r   <= bus.cmd_addr;
         wdata_r <= bus.wdata;
      end
      if (state == START && tick && q == 2'd1) shreg <= {DEV_ADDR, 1'b0};
      else if (state == RSTART && q_end) shreg <= {DEV_ADDR, 1'b1};
      else if (state == ACK && q_end && !ack_bit)
         shreg <= (byte_idx == 2'd0) ? cmd_r : wdata_r;
      else if (state == TXBIT && q_end) shreg <= {shreg[6:0], 1'b0};
      else if (state == RXBIT && tick && q == 2'd2) shreg <= {shreg[6:0], bus.sda_in};
   end

   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.ack_err = ack_err;
   assign bus.rdata   = rdata;
   assign bus.scl_oe  = scl_oe;
   assign bus.sda_oe  = sda_oe;
endmodule

// File: tb/tb_i2c_9555_master.sv
// Bench for i2c_9555_master: bus-level expander slave model plus a token scoreboard.
// Tokens: 0x200 START, 0x201 STOP, otherwise {ack_bit, byte} seen on the wires.
module tb_i2c_9555_master;
   localparam int CLK_HZ = 50_000_000;
   localparam int SCL_HZ = 1_000_000;
   localparam int QTR    = CLK_HZ / (4 * SCL_HZ);
   localparam int WR_CYC = 115 * QTR + 1;
   localparam int RD_CYC = 155 * QTR + 1;
   localparam int NA_CYC = 43 * QTR + 1;
   localparam int TOK_S  = 32'h200;
   localparam int TOK_P  = 32'h201;

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   always #5 clk = ~clk;

   i2c_9555_master_if bus();

   i2c_9555_master #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(7'h20)) dut (
      .clk  (clk),
      .rst_l(rst_l),
      .bus  (bus)
   );

   logic       slv_sda_low = 1'b0;
   logic       slv_scl_low = 1'b0;
   logic       nack_all    = 1'b0;
   logic       stretch_en  = 1'b0;
   logic [7:0] slv_rbyte   = 8'h3C;

   assign bus.scl_in = !(bus.scl_oe || slv_scl_low);
   assign bus.sda_in = !(bus.sda_oe || slv_sda_low);

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int obs_q[$];
   int done_cnt;
   int busy_cyc;

   // Slave model and bus monitor, sampled on the falling system clock edge.
   initial begin : slave
      logic       pscl, psda, scl, sda, tx_mode;
      logic [7:0] sh, tx_sh;
      int         bitn, byte_cnt, hold;
      pscl = 1'b1; psda = 1'b1; tx_mode = 1'b0; sh = 8'h00; tx_sh = 8'h00;
      bitn = 0; byte_cnt = 0; hold = 0;
      forever begin
         @(negedge clk);
         scl = bus.scl_in;
         sda = bus.sda_in;
         if (!rst_l) begin
            slv_sda_low = 1'b0; slv_scl_low = 1'b0;
            tx_mode = 1'b0; bitn = 0; byte_cnt = 0; hold = 0;
         end else begin
            if (hold > 0) begin
               hold--;
               if (hold == 0) slv_scl_low = 1'b0;
            end
            if (pscl && scl && psda && !sda) begin
               obs_q.push_back(TOK_S);
               bitn = 0; byte_cnt = 0; tx_mode = 1'b0;
            end else if (pscl && scl && !psda && sda) begin
               obs_q.push_back(TOK_P);
               bitn = 0; tx_mode = 1'b0; slv_sda_low = 1'b0;
            end else if (!pscl && scl) begin
               if (bitn < 8) begin
                  sh = {sh[6:0], sda};
                  bitn++;
               end else begin
                  obs_q.push_back(int'({sda, sh}));
                  if (byte_cnt == 0) begin
                     if (sh[7:1] == 7'h20 && !nack_all && sh[0] && !sda) begin
                        tx_mode = 1'b1;
                        tx_sh   = slv_rbyte;
                     end
                  end else if (tx_mode && sda) tx_mode = 1'b0;
                  bitn = 0;
                  byte_cnt++;
               end
            end else if (pscl && !scl) begin
               if (bitn == 8)
                  slv_sda_low = !tx_mode && (byte_cnt != 0 || (sh[7:1] == 7'h20 && !nack_all));
               else if (tx_mode) begin
                  slv_sda_low = !tx_sh[7];
                  tx_sh = {tx_sh[6:0], 1'b0};
               end else slv_sda_low = 1'b0;
               if (stretch_en && byte_cnt == 1 && bitn == 3) begin
                  slv_scl_low = 1'b1;
                  hold = 1000;
               end
            end
         end
         pscl = scl;
         psda = sda;
      end
   end

   task automatic launch(input logic rw, input logic [7:0] cmd, input logic [7:0] wd);
      @(negedge clk);
      obs_q.delete();
      bus.start = 1'b1; bus.rw = rw; bus.cmd_addr = cmd; bus.wdata = wd;
   endtask

   // Counts busy cycles and done pulses up to done (bounded), then for a tail window.
   task automatic wait_done(input int budget, input int tail, input int inject_at);
      int n;
      n = 0; done_cnt = 0; busy_cyc = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         bus.start = 1'b0;
         n++;
         if (n == inject_at) begin
            bus.start = 1'b1; bus.rw = 1'b1; bus.cmd_addr = 8'h77; bus.wdata = 8'h11;
         end
         if (bus.busy) busy_cyc++;
         if (bus.done) done_cnt++;
      end
      repeat (tail) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.busy) busy_cyc++;
         if (bus.done) done_cnt++;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.rw = 1'b0; bus.cmd_addr = 8'h00; bus.wdata = 8'h00;
      rst_l = 1'b0;
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      repeat (2) @(negedge clk);
      checks += 6;
      if (bus.scl_oe !== 1'b0) begin failures++; $display("FAIL reset_scl_oe got=%b exp=0", bus.scl_oe); end
      if (bus.sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda_oe got=%b exp=0", bus.sda_oe); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); end
      if (bus.rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
   endtask

   task automatic test_write();
      launch(1'b0, 8'h02, 8'hA5);
      exp_q = '{TOK_S, 32'h040, 32'h002, 32'h0A5, TOK_P};
      wait_done(3 * WR_CYC, 20, 0);
      checks += 4;
      if (done_cnt !== 1) begin failures++; $display("FAIL write_done_pulses got=%0d exp=1", done_cnt); end
      if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL write_ack_err got=%b exp=0", bus.ack_err); end
      if (busy_cyc < WR_CYC - 1 || busy_cyc > WR_CYC + 3) begin
         failures++; $display("FAIL write_busy_cycles got=%0d exp=%0d", busy_cyc, WR_CYC);
      end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL write_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL write_token got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_read();
      slv_rbyte = 8'h3C;
      launch(1'b1, 8'h00, 8'hFF);
      exp_q = '{TOK_S, 32'h040, 32'h000, TOK_S, 32'h041, 32'h13C, TOK_P};
      wait_done(3 * RD_CYC, 20, 0);
      checks += 5;
      if (done_cnt !== 1) begin failures++; $display("FAIL read_done_pulses got=%0d exp=1", done_cnt); end
      if (bus.rdata !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h exp=3c", bus.rdata); end
      if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL read_ack_err got=%b exp=0", bus.ack_err); end
      if (busy_cyc < RD_CYC - 1 || busy_cyc > RD_CYC + 3) begin
         failures++; $display("FAIL read_busy_cycles got=%0d exp=%0d", busy_cyc, RD_CYC);
      end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL read_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL read_token got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_no_device();
      nack_all = 1'b1;
      launch(1'b1, 8'h01, 8'h00);
      exp_q = '{TOK_S, 32'h140, TOK_P};
      wait_done(3 * NA_CYC, 20, 0);
      nack_all = 1'b0;
      checks += 4;
      if (done_cnt !== 1) begin failures++; $display("FAIL nodev_done_pulses got=%0d exp=1", done_cnt); end
      if (bus.ack_err !== 1'b1) begin failures++; $display("FAIL nodev_ack_err got=%b exp=1", bus.ack_err); end
      if (bus.rdata !== 8'h3C) begin failures++; $display("FAIL nodev_rdata_held got=%h exp=3c", bus.rdata); end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL nodev_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL nodev_token got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_stretch();
      stretch_en = 1'b1;
      launch(1'b0, 8'h06, 8'h5A);
      exp_q = '{TOK_S, 32'h040, 32'h006, 32'h05A, TOK_P};
      wait_done(3 * WR_CYC + 2000, 20, 0);
      stretch_en = 1'b0;
      checks += 3;
      if (done_cnt !== 1) begin failures++; $display("FAIL stretch_done_pulses got=%0d exp=1", done_cnt); end
      if (busy_cyc < WR_CYC + 1000 - 3 * QTR || busy_cyc > WR_CYC + 1000 + QTR) begin
         failures++; $display("FAIL stretch_busy_cycles got=%0d exp=~%0d", busy_cyc, WR_CYC + 1000 - 2 * QTR);
      end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL stretch_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL stretch_token got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_start_while_busy();
      launch(1'b0, 8'h07, 8'h96);
      exp_q = '{TOK_S, 32'h040, 32'h007, 32'h096, TOK_P};
      wait_done(3 * WR_CYC, 60 * QTR, 25 * QTR);
      checks += 4;
      if (done_cnt !== 1) begin failures++; $display("FAIL busy_start_done_pulses got=%0d exp=1", done_cnt); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", bus.busy); end
      if (busy_cyc < WR_CYC - 1 || busy_cyc > WR_CYC + 3) begin
         failures++; $display("FAIL busy_start_cycles got=%0d exp=%0d", busy_cyc, WR_CYC);
      end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL busy_start_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL busy_start_token got=%h exp=%h", o, e); end
      end
   endtask

   task automatic test_reset_mid_read();
      launch(1'b1, 8'h01, 8'h00);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (131 * QTR) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrd_busy_before got=%b exp=1", bus.busy); end
      #2 rst_l = 1'b0;
      #1;
      checks += 3;
      if (bus.scl_oe !== 1'b0) begin failures++; $display("FAIL midrd_scl_oe got=%b exp=0", bus.scl_oe); end
      if (bus.sda_oe !== 1'b0) begin failures++; $display("FAIL midrd_sda_oe got=%b exp=0", bus.sda_oe); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrd_busy got=%b exp=0", bus.busy); end
      repeat (3) @(negedge clk);
      rst_l = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.rdata !== 8'h00) begin failures++; $display("FAIL midrd_rdata_reset got=%h exp=00", bus.rdata); end
      launch(1'b0, 8'h03, 8'hC3);
      exp_q = '{TOK_S, 32'h040, 32'h003, 32'h0C3, TOK_P};
      wait_done(3 * WR_CYC, 20, 0);
      checks += 3;
      if (done_cnt !== 1) begin failures++; $display("FAIL midrd_after_done got=%0d exp=1", done_cnt); end
      if (bus.ack_err !== 1'b0) begin failures++; $display("FAIL midrd_after_ack_err got=%b exp=0", bus.ack_err); end
      if (obs_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL midrd_token_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         int e, o;
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin failures++; $display("FAIL midrd_token got=%h exp=%h", o, e); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_no_device();
      test_stretch();
      test_start_while_busy();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
